// File: rtl/pc_sequencer.sv
// Multi-cycle control sequencer driving the PC update interface.
// Latches the fetched instruction, walks it through IF/ID/EXE/MEM/WB and
// raises PCWre for exactly one cycle in the final state of each instruction.
module pc_sequencer #(
  parameter logic [5:0]  HALT_OP  = 6'b111111,
  parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  PC4,
  input  logic        Zero,
  output logic        PCWre,
  output logic [1:0]  PCSrc,
  output logic [15:0] Immediate,
  output logic [31:0] JumpPC,
  output logic        IRWre,
  output logic        RegWre,
  output logic        MemWrite,
  output logic [2:0]  State,
  output logic        IllegalOp
);

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StExe  = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e      state_q;
  logic [31:0] ir_q;
  logic        illegal_q;
  // Low for the reset cycle and the one after release, so the first real IF
  // starts on the first posedge after Reset deasserts.
  logic        run_q;

  logic [5:0] opcode;
  logic       op_halt, op_alu, op_lw, op_sw, op_beq, op_bne, op_j, op_unknown;

  // Opcode decode; HALT_OP takes precedence over every other encoding.
  always_comb begin
    opcode     = ir_q[31:26];
    op_halt    = (opcode == HALT_OP);
    op_alu     = !op_halt && ((opcode == OpRtype) || (opcode == OpAddi) || (opcode == OpOri));
    op_lw      = !op_halt && (opcode == OpLw);
    op_sw      = !op_halt && (opcode == OpSw);
    op_beq     = !op_halt && (opcode == OpBeq);
    op_bne     = !op_halt && (opcode == OpBne);
    op_j       = !op_halt && (opcode == OpJ);
    op_unknown = !op_halt && !(op_alu || op_lw || op_sw || op_beq || op_bne || op_j);
  end

  // State sequencing, IR latch and sticky illegal-opcode flag.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIf;
      ir_q      <= RESET_IR;
      illegal_q <= 1'b0;
      run_q     <= 1'b0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIf: begin
          ir_q    <= Instr;
          state_q <= StId;
        end
        StId: begin
          if (op_halt) begin
            state_q <= StHalt;
          end else if (op_j) begin
            state_q <= StIf;
          end else if (op_unknown) begin
            illegal_q <= 1'b1;
            state_q   <= StIf;
          end else begin
            state_q <= StExe;
          end
        end
        StExe: begin
          if (op_beq || op_bne) begin
            state_q <= StIf;
          end else if (op_lw || op_sw) begin
            state_q <= StMem;
          end else begin
            state_q <= StWb;
          end
        end
        StMem:   state_q <= op_sw ? StIf : StWb;
        StWb:    state_q <= StIf;
        StHalt:  state_q <= StHalt;
        default: state_q <= StIf;
      endcase
    end
  end

  // Strobes and next-PC select; PCSrc stays 00 unless PCWre is asserted.
  always_comb begin
    PCWre    = 1'b0;
    PCSrc    = 2'b00;
    IRWre    = 1'b0;
    RegWre   = 1'b0;
    MemWrite = 1'b0;
    unique case (state_q)
      StIf: IRWre = run_q;
      StId: begin
        if (op_j || op_unknown) begin
          PCWre = 1'b1;
          if (op_j) PCSrc = 2'b10;
        end
      end
      StExe: begin
        if (op_beq || op_bne) begin
          PCWre = 1'b1;
          if ((op_beq && Zero) || (op_bne && !Zero)) PCSrc = 2'b01;
        end
      end
      StMem: begin
        if (op_sw) begin
          PCWre    = 1'b1;
          MemWrite = 1'b1;
        end
      end
      StWb: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      default: ;
    endcase
  end

  assign State     = state_q;
  assign Immediate = ir_q[15:0];
  assign JumpPC    = {PC4, ir_q[25:0], 2'b00};
  assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-cycle expectations are queued when
// an instruction is driven and popped as the sequencer steps through it.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] Instr;
  logic [3:0]  PC4;
  logic        Zero;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [15:0] Immediate;
  logic [31:0] JumpPC;
  logic        IRWre;
  logic        RegWre;
  logic        MemWrite;
  logic [2:0]  State;
  logic        IllegalOp;

  pc_sequencer dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Instr     (Instr),
    .PC4       (PC4),
    .Zero      (Zero),
    .PCWre     (PCWre),
    .PCSrc     (PCSrc),
    .Immediate (Immediate),
    .JumpPC    (JumpPC),
    .IRWre     (IRWre),
    .RegWre    (RegWre),
    .MemWrite  (MemWrite),
    .State     (State),
    .IllegalOp (IllegalOp)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  st;
    logic        pcwre;
    logic [1:0]  pcsrc;
    logic        regwre;
    logic        memwrite;
    logic        irwre;
    logic        chk_ir;
    logic [15:0] imm;
    logic [31:0] jpc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: expected per-cycle outputs for one instruction.
  task automatic push_instr(input logic [31:0] ins, input logic z, input logic [3:0] pc4);
    logic [5:0] op;
    logic [2:0] seq[$];
    logic       halt;
    logic       last;
    exp_t       e;
    op   = ins[31:26];
    halt = (op == 6'h3f);
    case (op)
      6'h00, 6'h08, 6'h0d: seq = '{3'd0, 3'd1, 3'd2, 3'd4};
      6'h23:               seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      6'h2b:               seq = '{3'd0, 3'd1, 3'd2, 3'd3};
      6'h04, 6'h05:        seq = '{3'd0, 3'd1, 3'd2};
      default:             seq = '{3'd0, 3'd1};
    endcase
    if (halt) for (int k = 0; k < 20; k++) seq.push_back(3'd5);
    for (int i = 0; i < seq.size(); i++) begin
      last       = (i == seq.size() - 1) && !halt;
      e.st       = seq[i];
      e.pcwre    = last;
      e.pcsrc    = 2'b00;
      if (last && op == 6'h02) e.pcsrc = 2'b10;
      if (last && ((op == 6'h04 && z) || (op == 6'h05 && !z))) e.pcsrc = 2'b01;
      e.regwre   = (seq[i] == 3'd4);
      e.memwrite = (seq[i] == 3'd3) && (op == 6'h2b);
      e.irwre    = (seq[i] == 3'd0);
      e.chk_ir   = (seq[i] != 3'd0);
      e.imm      = ins[15:0];
      e.jpc      = {pc4, ins[25:0], 2'b00};
      sb.push_back(e);
    end
  endtask

  // Drives one instruction from an IF cycle (called at a negedge) and scores
  // every cycle until the next IF.
  task automatic run_instr(input string name, input logic [31:0] ins, input logic z);
    exp_t       e;
    int         cyc;
    logic [8:0] act, req;
    Instr = ins;
    Zero  = z;
    push_instr(ins, z, PC4);
    cyc = 0;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {State, PCWre, PCSrc, RegWre, MemWrite, IRWre};
      req = {e.st, e.pcwre, e.pcsrc, e.regwre, e.memwrite, e.irwre};
      n_cmp++;
      if (act !== req) begin
        n_err++;
        $display("FAIL %s cyc%0d ctl {st,pcwre,pcsrc,reg,mem,ir}: got %b want %b",
                 name, cyc, act, req);
      end
      if (e.chk_ir) begin
        n_cmp++;
        if ({Immediate, JumpPC} !== {e.imm, e.jpc}) begin
          n_err++;
          $display("FAIL %s cyc%0d imm/jpc: got %h/%h want %h/%h",
                   name, cyc, Immediate, JumpPC, e.imm, e.jpc);
        end
      end
      @(negedge CLK);
      cyc++;
    end
    if (ins[31:26] != 6'h3f) begin
      n_cmp++;
      if (State !== 3'd0) begin
        n_err++;
        $display("FAIL %s next_if: State got %0d want 0", name, State);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Instr = 32'h0000_0820;
    PC4   = 4'h0;
    Zero  = 1'b0;
    #12;
    n_cmp++;
    if ({State, PCWre, PCSrc, IRWre, RegWre, MemWrite, IllegalOp, Immediate} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_state: got st=%0d pcwre=%b pcsrc=%b ir=%b reg=%b mem=%b ill=%b imm=%h",
               State, PCWre, PCSrc, IRWre, RegWre, MemWrite, IllegalOp, Immediate);
    end
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    n_cmp++;
    if ({State, IRWre} !== 4'b000_0) begin
      n_err++;
      $display("FAIL reset_release: got st=%0d irwre=%b want 0/0", State, IRWre);
    end
    @(negedge CLK);
    n_cmp++;
    if ({State, IRWre} !== 4'b000_1) begin
      n_err++;
      $display("FAIL first_if: got st=%0d irwre=%b want 0/1", State, IRWre);
    end
  endtask

  task automatic test_alu();
    run_instr("add", 32'h0000_0820, 1'b0);
    run_instr("addi", 32'h2001_7FFF, 1'b1);
    run_instr("ori", 32'h3401_8000, 1'b0);
  endtask

  task automatic test_branch();
    run_instr("beq_z1", 32'h1000_0003, 1'b1);
    run_instr("beq_z0", 32'h1000_0003, 1'b0);
    run_instr("bne_z1", 32'h1400_FFFC, 1'b1);
    run_instr("bne_z0", 32'h1400_FFFC, 1'b0);
  endtask

  task automatic test_jump();
    PC4 = 4'h0;
    run_instr("j_pc0", 32'h0800_0010, 1'b0);
    n_cmp++;
    if (JumpPC !== 32'h0000_0040) begin
      n_err++;
      $display("FAIL j_target: got %h want 00000040", JumpPC);
    end
    PC4 = 4'hA;
    run_instr("j_pcA", 32'h0BFF_FFFF, 1'b1);
    PC4 = 4'h0;
  endtask

  task automatic test_back_to_back();
    run_instr("lw", 32'h8C01_0004, 1'b0);
    run_instr("sw", 32'hAC01_0004, 1'b1);
    run_instr("lw2", 32'h8C01_0004, 1'b1);
  endtask

  task automatic test_illegal();
    n_cmp++;
    if (IllegalOp !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_pre: got %b want 0", IllegalOp);
    end
    run_instr("illegal", 32'h7C00_0000, 1'b0);
    n_cmp++;
    if (IllegalOp !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_set: got %b want 1", IllegalOp);
    end
    run_instr("after_ill", 32'h0000_0820, 1'b0);
    n_cmp++;
    if (IllegalOp !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_sticky: got %b want 1", IllegalOp);
    end
  endtask

  task automatic test_reset_mid();
    Instr = 32'h0000_0820;
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (State !== 3'd2) begin
      n_err++;
      $display("FAIL mid_exe: State got %0d want 2", State);
    end
    #2 Reset = 1'b0;
    #1;
    n_cmp++;
    if ({State, PCWre, PCSrc, RegWre, IllegalOp, Immediate, JumpPC} !== 56'd0) begin
      n_err++;
      $display("FAIL mid_reset: st=%0d pcwre=%b pcsrc=%b reg=%b ill=%b imm=%h jpc=%h want all 0",
               State, PCWre, PCSrc, RegWre, IllegalOp, Immediate, JumpPC);
    end
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    n_cmp++;
    if ({State, PCWre, IRWre} !== 5'd0) begin
      n_err++;
      $display("FAIL mid_release: st=%0d pcwre=%b irwre=%b want 0/0/0", State, PCWre, IRWre);
    end
    @(negedge CLK);
    run_instr("add_recover", 32'h0000_0820, 1'b0);
  endtask

  task automatic test_halt();
    run_instr("halt", 32'hFC00_0000, 1'b1);
    n_cmp++;
    if ({State, PCWre, PCSrc, IRWre} !== 7'b101_0_00_0) begin
      n_err++;
      $display("FAIL halt_hold: st=%0d pcwre=%b pcsrc=%b irwre=%b want 5/0/00/0",
               State, PCWre, PCSrc, IRWre);
    end
    #2 Reset = 1'b0;
    #1;
    n_cmp++;
    if ({State, PCWre} !== 4'd0) begin
      n_err++;
      $display("FAIL halt_reset: st=%0d pcwre=%b want 0/0", State, PCWre);
    end
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    run_instr("beq_after_halt", 32'h1000_0003, 1'b1);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_jump();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control sequencer that drives the program-counter update interface: PCWre, PCSrc, Immediate and JumpPC.
- Latches the fetched instruction, steps it through IF/ID/EXE/MEM/WB and asserts PCWre in the final state of each instruction.
- Selects sequential, branch or jump next-PC.
- Sits between instruction memory, the ALU Zero flag and the PC register.

Parameters:
- HALT_OP, 6'b111111, opcode that parks the sequencer in HALT.
- RESET_IR, 32'h0000_0000, instruction register value after reset.

Ports:
- CLK  input  1  system clock; state and IR update on posedge.
- Reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
- Instr  input  32  instruction-memory read data for the current PC address.
- PC4  input  4  upper PC bits [31:28] from the PC register.
- Zero  input  1  ALU zero flag, valid during EXE.
- PCWre  output  1  PC write enable; PC consumes it on the negedge within the same cycle.
- PCSrc  output  2  next-PC select: 00 = PC+4, 01 = branch, 10 = jump; 11 is never driven.
- Immediate  output  16  IR[15:0], consumed by the PC for branch offsets.
- JumpPC  output  32  {PC4, IR[25:0], 2'b00}.
- IRWre  output  1  high in IF (IR load strobe).
- RegWre  output  1  register-file write strobe, high in WB only.
- MemWrite  output  1  high in MEM for sw only.
- State  output  3  encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5.
- IllegalOp  output  1  sticky; set on decode of an unknown opcode.

Behaviour:
- Reset (Reset==0, asynchronous):
  - State=IF, IR=RESET_IR, IllegalOp=0.
  - PCWre=0, PCSrc=00, IRWre=0, RegWre=0, MemWrite=0.
  - Reset in any state, including HALT, aborts the instruction; no PCWre pulse is emitted.
  - First IF begins on the first posedge after Reset deasserts.
- IR is loaded from Instr on the posedge that leaves IF. It is otherwise held.
- Opcode = IR[31:26]. Per-opcode state sequences; PCWre=1 only in the final state listed:
  - R-type 000000, addi 001000, ori 001101: IF→ID→EXE→WB, PCSrc=00.
  - lw 100011: IF→ID→EXE→MEM→WB, PCSrc=00.
  - sw 101011: IF→ID→EXE→MEM, PCSrc=00, MemWrite=1 in MEM.
  - beq 000100: IF→ID→EXE, PCSrc=01 if Zero else 00.
  - bne 000101: IF→ID→EXE, PCSrc=01 if !Zero else 00.
  - j 000010: IF→ID, PCSrc=10.
  - HALT_OP: IF→ID→HALT. HALT is absorbing, with PCWre=0 and all strobes 0; only Reset exits.
  - Any other opcode: IF→ID with PCWre=1, PCSrc=00 (treated as nop); IllegalOp set and held until Reset.
- Output timing:
  - All outputs are combinational from State, IR and Zero; no extra latency.
  - PCWre is exactly one cycle wide per instruction.
  - PCSrc is 00 whenever PCWre=0.
  - Zero is sampled only in EXE for beq/bne and ignored elsewhere.
- Immediate and JumpPC are driven continuously from IR and PC4, so they are valid throughout every state.
- Final state always transitions to IF on the next posedge, except HALT.
- Cycles per instruction: j=2, beq/bne=3, R/addi/ori/sw=4, lw=5.

Test Plan:
- Reset low mid-EXE of an add → State=0, PCWre=0, IR=0 immediately; after release, IF at next posedge, IRWre=1.
- Instr=32'h0000_0820 (add) → states 0,1,2,4; PCWre=1 only in WB with PCSrc=00; RegWre=1 only in WB.
- Instr=32'h1000_0003 (beq), Zero=1 → EXE has PCWre=1, PCSrc=01, Immediate=16'h0003. Repeat with Zero=0 → PCSrc=00.
- Instr=32'h0800_0010 (j), PC4=4'h0 → ID has PCWre=1, PCSrc=10, JumpPC=32'h0000_0040; next state IF.
- Instr=32'h8C01_0004 (lw) then 32'hAC01_0004 (sw) → 5 and 4 cycles respectively; MemWrite=1 only in the sw MEM cycle.
- Instr=32'hFC00_0000 → HALT held for 20 cycles with PCWre=0. Separately, Instr=32'h7C00_0000 → IllegalOp=1 and stays 1 across following instructions until Reset.
